lcd_image_window: RTL and testbench
===================================

Name: lcd_image_window

Overview:
- Parametrised image-to-LCD pixel source: places an IMG_W x IMG_H image, read from an external synchronous ROM, at a frame-latched (x0, y0) offset on an H_DISP x V_DISP raster. Pixels outside the window get BG_COLOR.
- Generates ROM addresses with an incrementing counter rather than a multiplier.
- Expands grey8 / RGB565 / RGB888 ROM formats to 24-bit RGB.
- Delays data and valid so they stay aligned with the timing generator's coordinates.

Parameters:
- H_DISP, 640, active pixels per line.
- V_DISP, 480, active lines per frame.
- IMG_W, 640, image width in pixels (1..H_DISP).
- IMG_H, 480, image height in lines (1..V_DISP).
- ADDR_W, 19, ROM address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- ROM_LAT, 1, ROM read latency in clocks, from rom_addr to rom_q (1..4).
- MODE, 0, ROM pixel format: 0 = RGB888 in q[23:0]; 1 = grey8 in q[7:0]; 2 = RGB565 in q[15:0].
- BG_COLOR, 24'h000000, colour for in-raster pixels outside the window.

Ports:
- iCLK  in  1  pixel clock.
- iRST  in  1  reset; asynchronous, active-high.
- lcd_de  in  1  coordinates are valid (active area).
- lcd_xpos  in  11  horizontal coordinate, 0..H_DISP-1.
- lcd_ypos  in  11  vertical coordinate, 0..V_DISP-1.
- img_x0  in  11  requested window left edge; sampled at frame start.
- img_y0  in  11  requested window top edge; sampled at frame start.
- rom_addr  out  ADDR_W  ROM address (registered).
- rom_rd  out  1  ROM read enable (registered).
- rom_q  in  24  ROM data, valid ROM_LAT clocks after rom_addr/rom_rd; unused upper bits are ignored.
- lcd_data  out  24  RGB888 pixel, {R, G, B}.
- lcd_data_vld  out  1  lcd_data corresponds to an lcd_de pixel.

Behaviour:
- Reset (asynchronous assert, synchronous release to the first edge):
  - Registered outputs cleared: rom_addr = 0, rom_rd = 0, lcd_data = 0, lcd_data_vld = 0.
  - Internal state cleared: x0_q = 0, y0_q = 0, addr_cnt = 0, all delay lines = 0.
  - Reset mid-frame: output stays idle until the next frame start. Pixels of a partial frame before that may show BG_COLOR or image data, but lcd_data_vld must track lcd_de.
- Frame start (fs) = lcd_de && xpos == 0 && ypos == 0. On fs:
  - x0_q <= min(img_x0, H_DISP-IMG_W).
  - y0_q <= min(img_y0, V_DISP-IMG_H).
  - The fs pixel itself is evaluated with the clamped new offsets and an effective addr_cnt of 0.
  - img_x0/img_y0 changes at any other time have no effect.
- Window test (combinational, stage 0): in_win = lcd_de && x in [x0, x0+IMG_W) && y in [y0, y0+IMG_H), compared at 12-bit width so there is no overflow.
- Address counter:
  - Each in_win cycle: rom_addr <= addr_cnt, rom_rd <= 1, addr_cnt <= addr_cnt + 1.
  - After the last image pixel (IMG_W*IMG_H-1) the counter wraps to 0.
  - Not in_win: rom_rd <= 0, rom_addr holds.
  - Clamping keeps the window fully on-raster, so the raster-order count equals (y-y0)*IMG_W + (x-x0).
- Pipeline:
  - Input-to-output latency is L = ROM_LAT + 2 clocks, fixed in every mode.
  - in_win and lcd_de are delayed L-1 stages so they align with rom_q.
  - The output register loads formatted rom_q when delayed in_win = 1; otherwise BG_COLOR if delayed lcd_de = 1, else 0.
  - lcd_data_vld = lcd_de delayed by L.
- Format expansion (MODE is a static parameter):
  - MODE 0: q[23:0] passed through.
  - MODE 1: {q[7:0], q[7:0], q[7:0]}.
  - MODE 2: R = {q[15:11], q[15:13]}, G = {q[10:5], q[10:9]}, B = {q[4:0], q[4:2]}.
- lcd_de gaps (blanking) do not advance addr_cnt. The counter advances only on in_win.
- Simultaneous fs and in_win (window at the origin): rom_addr = 0 and addr_cnt <= 1.

Test Plan:
- Default parameters, offsets 0, full 640x480 frame, ROM model returns q = address: lcd_data at output cycle n equals input pixel n (x + 640*y) for every pixel; latency 3 clocks; lcd_data_vld mirrors lcd_de delayed 3.
- IMG_W=4, IMG_H=2, H_DISP=8, V_DISP=4, img_x0=2, img_y0=1, BG_COLOR=24'h123456:
  - pixel (2,1) gives image pixel 0 and (5,2) gives pixel 7;
  - (1,1), (6,1) and (2,3) give 24'h123456;
  - rom_rd is high for exactly 8 clocks per frame.
- Offset change mid-frame: img_x0 changes from 2 to 3 at (4,2) -> the current frame keeps x0 = 2, and the next frame's window starts at x = 3; img_x0 = 100 with IMG_W=4, H_DISP=8 -> clamped to 4.
- MODE 1 with q = 8'hA5 -> lcd_data = 24'hA5A5A5; MODE 2 with q = 16'hF81F -> 24'hFF00FF, and with q = 16'h07E0 -> 24'h00FF00.
- ROM_LAT=3 -> latency 5; an iRST pulse mid-line -> all outputs are 0 within the same cycle (asynchronous). Recovery: after the next fs, the first window pixel reads address 0.

Source files
------------

// File: rtl/lcd_image_window_if.sv
// Pixel-source bus: raster coordinates and window offsets in, ROM address/data,
// and the formatted RGB888 pixel out.
interface lcd_image_window_if #(
    parameter int unsigned ADDR_W = 19
);
    logic              lcd_de;
    logic [10:0]       lcd_xpos;
    logic [10:0]       lcd_ypos;
    logic [10:0]       img_x0;
    logic [10:0]       img_y0;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_rd;
    logic [23:0]       rom_q;
    logic [23:0]       lcd_data;
    logic              lcd_data_vld;

    modport master (
        input  lcd_de, lcd_xpos, lcd_ypos, img_x0, img_y0, rom_q,
        output rom_addr, rom_rd, lcd_data, lcd_data_vld
    );

    modport slave (
        output lcd_de, lcd_xpos, lcd_ypos, img_x0, img_y0, rom_q,
        input  rom_addr, rom_rd, lcd_data, lcd_data_vld
    );
endinterface

// File: rtl/lcd_image_window.sv
// Places an IMG_W x IMG_H ROM image at a frame-latched offset on the raster and
// expands the ROM pixel format to RGB888, keeping data aligned with lcd_de.
module lcd_image_window #(
    parameter int unsigned H_DISP   = 640,
    parameter int unsigned V_DISP   = 480,
    parameter int unsigned IMG_W    = 640,
    parameter int unsigned IMG_H    = 480,
    parameter int unsigned ADDR_W   = 19,
    parameter int unsigned ROM_LAT  = 1,
    parameter int unsigned MODE     = 0,
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input logic                iCLK,
    input logic                iRST,
    lcd_image_window_if.master bus
);
    localparam logic [11:0]       X_MAX     = 12'(H_DISP - IMG_W);
    localparam logic [11:0]       Y_MAX     = 12'(V_DISP - IMG_H);
    localparam logic [11:0]       W12       = 12'(IMG_W);
    localparam logic [11:0]       H12       = 12'(IMG_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);
    localparam int unsigned       DLY       = ROM_LAT + 1;

    logic [11:0]       r_x0;
    logic [11:0]       r_y0;
    logic [ADDR_W-1:0] r_addr_cnt;
    logic [ADDR_W-1:0] r_rom_addr;
    logic              r_rom_rd;
    logic [DLY-1:0]    r_win_dly;
    logic [DLY-1:0]    r_de_dly;
    logic [23:0]       r_lcd_data;
    logic              r_lcd_data_vld;

    logic [11:0]       w_xpos;
    logic [11:0]       w_ypos;
    logic [11:0]       w_x0_clamp;
    logic [11:0]       w_y0_clamp;
    logic [11:0]       w_x0;
    logic [11:0]       w_y0;
    logic              w_fs;
    logic              w_in_win;
    logic [ADDR_W-1:0] w_cnt;
    logic [23:0]       w_pix;

    assign w_xpos = {1'b0, bus.lcd_xpos};
    assign w_ypos = {1'b0, bus.lcd_ypos};
    assign w_fs   = bus.lcd_de && (bus.lcd_xpos == 11'd0) && (bus.lcd_ypos == 11'd0);

    // Clamp keeps the whole window on-raster so a linear count matches raster order.
    assign w_x0_clamp = ({1'b0, bus.img_x0} > X_MAX) ? X_MAX : {1'b0, bus.img_x0};
    assign w_y0_clamp = ({1'b0, bus.img_y0} > Y_MAX) ? Y_MAX : {1'b0, bus.img_y0};

    // The frame-start pixel already uses the new offsets and a fresh count.
    assign w_x0  = w_fs ? w_x0_clamp : r_x0;
    assign w_y0  = w_fs ? w_y0_clamp : r_y0;
    assign w_cnt = w_fs ? '0 : r_addr_cnt;

    assign w_in_win = bus.lcd_de &&
                      (w_xpos >= w_x0) && (w_xpos < w_x0 + W12) &&
                      (w_ypos >= w_y0) && (w_ypos < w_y0 + H12);

    always_comb begin
        w_pix = bus.rom_q;
        case (MODE)
            1:       w_pix = {bus.rom_q[7:0], bus.rom_q[7:0], bus.rom_q[7:0]};
            2:       w_pix = {bus.rom_q[15:11], bus.rom_q[15:13],
                              bus.rom_q[10:5],  bus.rom_q[10:9],
                              bus.rom_q[4:0],   bus.rom_q[4:2]};
            default: w_pix = bus.rom_q;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_x0           <= '0;
            r_y0           <= '0;
            r_addr_cnt     <= '0;
            r_rom_addr     <= '0;
            r_rom_rd       <= 1'b0;
            r_win_dly      <= '0;
            r_de_dly       <= '0;
            r_lcd_data     <= '0;
            r_lcd_data_vld <= 1'b0;
        end else begin
            if (w_fs) begin
                r_x0 <= w_x0_clamp;
                r_y0 <= w_y0_clamp;
            end

            if (w_in_win) begin
                r_rom_addr <= w_cnt;
                r_addr_cnt <= (w_cnt == LAST_ADDR) ? '0 : w_cnt + 1'b1;
            end else if (w_fs) begin
                r_addr_cnt <= '0;
            end
            r_rom_rd <= w_in_win;

            // DLY stages line the window/de flags up with rom_q.
            r_win_dly <= {r_win_dly[DLY-2:0], w_in_win};
            r_de_dly  <= {r_de_dly[DLY-2:0], bus.lcd_de};

            if (r_win_dly[DLY-1]) begin
                r_lcd_data <= w_pix;
            end else if (r_de_dly[DLY-1]) begin
                r_lcd_data <= BG_COLOR;
            end else begin
                r_lcd_data <= '0;
            end
            r_lcd_data_vld <= r_de_dly[DLY-1];
        end
    end

    assign bus.rom_addr     = r_rom_addr;
    assign bus.rom_rd       = r_rom_rd;
    assign bus.lcd_data     = r_lcd_data;
    assign bus.lcd_data_vld = r_lcd_data_vld;
endmodule

// File: tb/tb_lcd_image_window.sv
// Three pixel-source instances on a shared 8x4 raster, scored against a
// coordinate-based reference model; latency, formats, clamping and async reset.
`timescale 1ns/1ps
module tb_lcd_image_window;
    localparam int HD = 8;
    localparam int VD = 4;
    localparam int AW = 5;
    localparam int WS [3]          = '{4, 8, 3};
    localparam int HS [3]          = '{2, 4, 3};
    localparam int LS [3]          = '{3, 5, 4};
    localparam int MS [3]          = '{0, 1, 2};
    localparam logic [23:0] BGS [3] = '{24'h123456, 24'h000000, 24'hABCDEF};

    typedef struct {
        logic [23:0] data;
        int          stamp;
        bit          dc;
        int          x;
        int          y;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        de  = 1'b0;
    logic [10:0] xp  = '0;
    logic [10:0] yp  = '0;
    logic [10:0] ix0 = '0;
    logic [10:0] iy0 = '0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          rd_cnt = 0;
    int          mx0 [3];
    int          my0 [3];
    bit          dc_frame = 1'b1;
    exp_t        sb [3][$];
    logic [23:0] rom1 [32];
    logic [23:0] rom2 [32];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lcd_image_window_if #(.ADDR_W(AW)) b0 ();
    lcd_image_window_if #(.ADDR_W(AW)) b1 ();
    lcd_image_window_if #(.ADDR_W(AW)) b2 ();

    assign b0.lcd_de = de;  assign b0.lcd_xpos = xp;  assign b0.lcd_ypos = yp;
    assign b0.img_x0 = ix0; assign b0.img_y0 = iy0;
    assign b1.lcd_de = de;  assign b1.lcd_xpos = xp;  assign b1.lcd_ypos = yp;
    assign b1.img_x0 = ix0; assign b1.img_y0 = iy0;
    assign b2.lcd_de = de;  assign b2.lcd_xpos = xp;  assign b2.lcd_ypos = yp;
    assign b2.img_x0 = ix0; assign b2.img_y0 = iy0;

    // ROM models: u0 returns its address, u1/u2 read random tables.
    logic [23:0] q0, q1a, q1b, q1c, q2a, q2b;
    always @(posedge clk) begin
        q0  <= 24'(b0.rom_addr);
        q1a <= rom1[b1.rom_addr];
        q1b <= q1a;
        q1c <= q1b;
        q2a <= rom2[b2.rom_addr];
        q2b <= q2a;
    end
    assign b0.rom_q = q0;
    assign b1.rom_q = q1c;
    assign b2.rom_q = q2b;

    lcd_image_window #(.H_DISP(HD), .V_DISP(VD), .IMG_W(4), .IMG_H(2), .ADDR_W(AW),
                       .ROM_LAT(1), .MODE(0), .BG_COLOR(24'h123456))
        u0 (.iCLK(clk), .iRST(rst), .bus(b0));
    lcd_image_window #(.H_DISP(HD), .V_DISP(VD), .IMG_W(8), .IMG_H(4), .ADDR_W(AW),
                       .ROM_LAT(3), .MODE(1), .BG_COLOR(24'h000000))
        u1 (.iCLK(clk), .iRST(rst), .bus(b1));
    lcd_image_window #(.H_DISP(HD), .V_DISP(VD), .IMG_W(3), .IMG_H(3), .ADDR_W(AW),
                       .ROM_LAT(2), .MODE(2), .BG_COLOR(24'hABCDEF))
        u2 (.iCLK(clk), .iRST(rst), .bus(b2));

    logic        vld_a  [3];
    logic [23:0] dat_a  [3];
    logic        rd_a   [3];
    logic [AW-1:0] adr_a [3];
    assign vld_a[0] = b0.lcd_data_vld; assign dat_a[0] = b0.lcd_data;
    assign vld_a[1] = b1.lcd_data_vld; assign dat_a[1] = b1.lcd_data;
    assign vld_a[2] = b2.lcd_data_vld; assign dat_a[2] = b2.lcd_data;
    assign rd_a[0]  = b0.rom_rd;       assign adr_a[0] = b0.rom_addr;
    assign rd_a[1]  = b1.rom_rd;       assign adr_a[1] = b1.rom_addr;
    assign rd_a[2]  = b2.rom_rd;       assign adr_a[2] = b2.rom_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] fmt(input int mode, input logic [23:0] q);
        int v, r, g, b;
        v = int'(q);
        if (mode == 1) begin
            g = v % 256;
            return 24'(g * 65536 + g * 256 + g);
        end else if (mode == 2) begin
            r = (v / 2048) % 32;
            g = (v / 32) % 64;
            b = v % 32;
            return 24'((r * 8 + r / 4) * 65536 + (g * 4 + g / 16) * 256 + (b * 8 + b / 4));
        end
        return q;
    endfunction

    function automatic exp_t model(input int k, input int x, input int y);
        exp_t        e;
        int          a;
        logic [23:0] q;
        e.stamp = cyc + LS[k];
        e.dc    = dc_frame;
        e.x     = x;
        e.y     = y;
        if (x >= mx0[k] && x < mx0[k] + WS[k] && y >= my0[k] && y < my0[k] + HS[k]) begin
            a = (y - my0[k]) * WS[k] + (x - mx0[k]);
            q = (k == 0) ? 24'(a) : (k == 1) ? rom1[a] : rom2[a];
            e.data = fmt(MS[k], q);
        end else begin
            e.data = BGS[k];
        end
        return e;
    endfunction

    task automatic drive_px(input bit d, input int x, input int y);
        @(posedge clk);
        #1;
        rd_cnt += int'(rd_a[0]);
        de = d;
        xp = 11'(x);
        yp = 11'(y);
        if (d) begin
            if (x == 0 && y == 0) begin
                dc_frame = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    mx0[k] = (int'(ix0) < HD - WS[k]) ? int'(ix0) : HD - WS[k];
                    my0[k] = (int'(iy0) < VD - HS[k]) ? int'(iy0) : VD - HS[k];
                end
            end
            for (int k = 0; k < 3; k++) sb[k].push_back(model(k, x, y));
        end
    endtask

    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        de  = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d async reset lcd_data", k), 32'(dat_a[k]), 32'h0);
            chk($sformatf("u%0d async reset lcd_data_vld", k), 32'(vld_a[k]), 32'h0);
            chk($sformatf("u%0d async reset rom_rd", k), 32'(rd_a[k]), 32'h0);
            chk($sformatf("u%0d async reset rom_addr", k), 32'(adr_a[k]), 32'h0);
            sb[k].delete();
        end
        dc_frame = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    task automatic run_frame(input int chg_at, input int new_x0, input int rst_at);
        bit was_reset = 1'b0;
        rd_cnt = 0;
        for (int y = 0; y < VD; y++) begin
            for (int x = 0; x < HD; x++) begin
                if (y * HD + x == chg_at) ix0 = 11'(new_x0);
                drive_px(1'b1, x, y);
                if (y * HD + x == rst_at) begin
                    pulse_reset();
                    was_reset = 1'b1;
                end
            end
            repeat ($urandom_range(1, 3)) drive_px(1'b0, HD - 1, y);
        end
        repeat (6) drive_px(1'b0, 0, 0);
        if (!was_reset) chk("u0 rom_rd cycles per frame", 32'(rd_cnt), 32'd8);
    endtask

    // Scoreboard monitor: pops one expectation per presented output.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (vld_a[k]) begin
                    if (sb[k].size() == 0) begin
                        chk($sformatf("u%0d lcd_data_vld with nothing expected", k),
                            32'd1, 32'd0);
                    end else begin
                        e = sb[k].pop_front();
                        chk($sformatf("u%0d latency of pixel(%0d,%0d)", k, e.x, e.y),
                            32'(cyc), 32'(e.stamp));
                        if (!e.dc)
                            chk($sformatf("u%0d pixel(%0d,%0d) data", k, e.x, e.y),
                                32'(dat_a[k]), 32'(e.data));
                    end
                end else begin
                    chk($sformatf("u%0d idle lcd_data", k), 32'(dat_a[k]), 32'h0);
                    if (sb[k].size() > 0 && sb[k][0].stamp <= cyc) begin
                        e = sb[k].pop_front();
                        chk($sformatf("u%0d lcd_data_vld for pixel(%0d,%0d)", k, e.x, e.y),
                            32'd0, 32'd1);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int rst_frame;
        for (int i = 0; i < 32; i++) begin
            rom1[i] = 24'($urandom);
            rom2[i] = 24'($urandom);
        end
        rom1[0] = 24'hFFFFA5;
        rom2[0] = 24'h12F81F;
        rom2[1] = 24'h0007E0;
        #1 rst = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d reset lcd_data", k), 32'(dat_a[k]), 32'h0);
            chk($sformatf("u%0d reset lcd_data_vld", k), 32'(vld_a[k]), 32'h0);
            chk($sformatf("u%0d reset rom_rd", k), 32'(rd_a[k]), 32'h0);
            chk($sformatf("u%0d reset rom_addr", k), 32'(adr_a[k]), 32'h0);
        end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) drive_px(1'b0, 0, 0);

        ix0 = 11'd2;
        iy0 = 11'd1;
        run_frame(-1, 0, -1);
        run_frame(2 * HD + 4, 3, -1);  // offset change mid-frame is ignored
        run_frame(-1, 0, -1);           // next frame picks up x0 = 3
        ix0 = 11'd100;
        iy0 = 11'd100;
        run_frame(-1, 0, -1);
        rst_frame = 3;
        for (int f = 0; f < 8; f++) begin
            ix0 = 11'($urandom_range(0, 9));
            iy0 = 11'($urandom_range(0, 5));
            if (f == rst_frame) run_frame(-1, 0, $urandom_range(9, 25));
            else                run_frame(-1, 0, -1);
        end
        repeat (10) drive_px(1'b0, 0, 0);
        for (int k = 0; k < 3; k++)
            chk($sformatf("u%0d outstanding expectations", k), 32'(sb[k].size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
